// File: rtl/seq_det_window_counter_if.sv
// -----------------------------------------------------------------------------
// seq_det_window_counter_if
//   Bundle between the 1011 detector side (master) and the window counter
//   (slave).
//
//   Parameter:
//     CNT_W      width of the count outputs
//
//   Signals:
//     det        detector output (Moore out), master -> slave
//     en         counting enable,             master -> slave
//     clr        synchronous clear,           master -> slave
//     total_cnt  saturating running total,    slave -> master
//     win_cnt    count of last closed window, slave -> master
//     win_valid  one-cycle window-close pulse, slave -> master
//     alarm      sticky threshold alarm,       slave -> master
// -----------------------------------------------------------------------------
interface seq_det_window_counter_if #(
  parameter int CNT_W = 8
);
  logic             det;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             win_valid;
  logic             alarm;

  modport master (
    output det,
    output en,
    output clr,
    input  total_cnt,
    input  win_cnt,
    input  win_valid,
    input  alarm
  );

  modport slave (
    input  det,
    input  en,
    input  clr,
    output total_cnt,
    output win_cnt,
    output win_valid,
    output alarm
  );
endinterface

// File: rtl/seq_det_window_counter.sv
// -----------------------------------------------------------------------------
// seq_det_window_counter
//   Counts rising edges of the sequence detector output while enabled. Keeps a
//   saturating running total and reports per-window counts over back-to-back
//   windows of WIN_LEN cycles. All outputs are registered.
//
//   Optional feature (macro SEQ_DET_WIN_ALARM_EN):
//     defined   -> alarm latches high when a closed window count >= THRESH,
//                  cleared only by clr or rst.
//     undefined -> alarm is tied low and no compare logic exists.
//
//   Parameters:
//     CNT_W    width of all counts (2..32)
//     WIN_LEN  window length in clock cycles (>= 2)
//     THRESH   alarm threshold for a closed window count
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-low reset
//     bus      seq_det_window_counter_if.slave
//                in : det, en, clr (clr is synchronous, highest priority)
//                out: total_cnt, win_cnt, win_valid, alarm
// -----------------------------------------------------------------------------
module seq_det_window_counter #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  seq_det_window_counter_if.slave       bus
);

  localparam int WC_W = $clog2(WIN_LEN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);

  // Elaboration-time parameter sanity checks.
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_det_window_counter: CNT_W must be in 2..32");
  end
  if (WIN_LEN < 2) begin : g_bad_win_len
    $error("seq_det_window_counter: WIN_LEN must be >= 2");
  end
  if (THRESH < 0) begin : g_bad_thresh
    $error("seq_det_window_counter: THRESH must be non-negative");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic             det_q;
  logic [WC_W-1:0]  wc;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] win_q;
  logic             valid_q;

  logic             ev;
  logic [CNT_W-1:0] total_nxt;
  logic [CNT_W-1:0] acc_nxt;

  // Increment by one bit, clamping at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic             b);
    if (b && (a != '1)) begin
      sat_inc = a + CNT_W'(1);
    end else begin
      sat_inc = a;
    end
  endfunction

  // A held-high det counts once: only its rising edge is an event.
  always_comb begin
    ev        = bus.det & ~det_q & bus.en;
    total_nxt = sat_inc(total_q, ev);
    acc_nxt   = sat_inc(acc, ev);
  end

`ifdef SEQ_DET_WIN_ALARM_EN
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  logic alarm_q;
  logic over_thresh;

  // acc_nxt is the closing count when the window closes on this edge.
  always_comb begin
    over_thresh = (32'(acc_nxt) >= THRESH_U);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      det_q   <= 1'b0;
      wc      <= '0;
      acc     <= '0;
      total_q <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
`ifdef SEQ_DET_WIN_ALARM_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      // Edge detector history follows det regardless of en/clr.
      det_q   <= bus.det;
      valid_q <= 1'b0;

      if (bus.clr) begin
        state   <= IDLE;
        wc      <= '0;
        acc     <= '0;
        total_q <= '0;
        win_q   <= '0;
`ifdef SEQ_DET_WIN_ALARM_EN
        alarm_q <= 1'b0;
`endif
      end else begin
        total_q <= total_nxt;

        unique case (state)
          IDLE: begin
            if (bus.en) begin
              // This edge is window cycle 0.
              state <= RUN;
              wc    <= WC_W'(1);
              acc   <= CNT_W'(ev);
            end else begin
              wc  <= '0;
              acc <= '0;
            end
          end

          RUN: begin
            if (!bus.en) begin
              // Partial window is dropped; published results are kept.
              state <= IDLE;
              wc    <= '0;
              acc   <= '0;
            end else if (wc == WC_LAST) begin
              // Close and immediately begin the next window (no gap cycle).
              win_q   <= acc_nxt;
              valid_q <= 1'b1;
              acc     <= '0;
              wc      <= '0;
`ifdef SEQ_DET_WIN_ALARM_EN
              if (over_thresh) begin
                alarm_q <= 1'b1;
              end
`endif
            end else begin
              wc  <= wc + WC_W'(1);
              acc <= acc_nxt;
            end
          end

          default: begin
            state <= IDLE;
            wc    <= '0;
            acc   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.total_cnt = total_q;
  assign bus.win_cnt   = win_q;
  assign bus.win_valid = valid_q;
`ifdef SEQ_DET_WIN_ALARM_EN
  assign bus.alarm     = alarm_q;
`else
  assign bus.alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_window_counter.sv
// -----------------------------------------------------------------------------
// tb_seq_det_window_counter
//   Self-checking bench for seq_det_window_counter with default parameters.
//   The reference model treats a window as a list of per-cycle event flags:
//   a window closes when the list holds WIN_LEN entries, and dropping en
//   discards the list. Honors SEQ_DET_WIN_ALARM_EN like the design.
// -----------------------------------------------------------------------------
module tb_seq_det_window_counter;

  localparam int CNT_W   = 8;
  localparam int WIN_LEN = 16;
  localparam int THRESH  = 3;
  localparam int MAXV    = 255;

`ifdef SEQ_DET_WIN_ALARM_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seq_det_window_counter_if #(.CNT_W(CNT_W)) bus ();

  seq_det_window_counter #(
    .CNT_W   (CNT_W),
    .WIN_LEN (WIN_LEN),
    .THRESH  (THRESH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  bit m_det_q;
  int m_total;
  int m_win;
  bit m_valid;
  bit m_alarm;
  bit m_q[$];

  typedef struct {
    bit det;
    bit en;
    bit clr;
    int total;
    int win;
    bit valid;
    bit alarm;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
               name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_det_q = 1'b0;
    m_total = 0;
    m_win   = 0;
    m_valid = 1'b0;
    m_alarm = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit d, input bit e, input bit c);
    bit ev;
    int sum;
    ev      = d && !m_det_q && e;
    m_det_q = d;
    m_valid = 1'b0;
    if (c) begin
      m_total = 0;
      m_win   = 0;
      m_alarm = 1'b0;
      m_q.delete();
    end else begin
      if (ev && m_total < MAXV) m_total++;
      if (!e) begin
        m_q.delete();
      end else begin
        m_q.push_back(ev);
        if (m_q.size() == WIN_LEN) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          m_win   = (sum > MAXV) ? MAXV : sum;
          m_valid = 1'b1;
          if (AL && m_win >= THRESH) m_alarm = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_model();
    check("mdl_total", 32'(bus.total_cnt), m_total);
    check("mdl_win",   32'(bus.win_cnt),   m_win);
    check("mdl_valid", 32'(bus.win_valid), 32'(m_valid));
    check("mdl_alarm", 32'(bus.alarm),     32'(m_alarm));
  endtask

  // Drive one cycle: inputs settle between edges, outputs sampled 1 after.
  task automatic cycle(input bit d, input bit e, input bit c);
    bus.det = d;
    bus.en  = e;
    bus.clr = c;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(d, e, c);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic check_outs(input string tag, input int total, input int win,
                            input bit valid, input bit alarm);
    check({tag, "_total"}, 32'(bus.total_cnt), total);
    check({tag, "_win"},   32'(bus.win_cnt),   win);
    check({tag, "_valid"}, 32'(bus.win_valid), 32'(valid));
    check({tag, "_alarm"}, 32'(bus.alarm),     32'(alarm));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nwin;

    // Window-count vectors: en from edge 0, det pulses at edges 2, 6, 11.
    for (int k = 0; k < 17; k++) begin
      tbl[k].det   = (k == 2 || k == 6 || k == 11);
      tbl[k].en    = 1'b1;
      tbl[k].clr   = 1'b0;
      tbl[k].total = (k >= 11) ? 3 : (k >= 6) ? 2 : (k >= 2) ? 1 : 0;
      tbl[k].win   = (k >= 15) ? 3 : 0;
      tbl[k].valid = (k == 15);
      tbl[k].alarm = AL && (k >= 15);
    end

    bus.det = 1'b0;
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    model_reset();

    // Reset held low for 3 cycles with det toggling.
    for (int i = 0; i < 3; i++) begin
      cycle(i[0], 1'b0, 1'b0);
      check_outs("rst_hold", 0, 0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(i < 2 ? i[0] : 1'b0, 1'b0, 1'b0);
      check_outs("rst_release", 0, 0, 1'b0, 1'b0);
    end

    // Table-driven window count.
    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].det, tbl[k].en, tbl[k].clr);
      check_outs("tbl", tbl[k].total, tbl[k].win, tbl[k].valid, tbl[k].alarm);
    end

    // Level filtering: det high 5 cycles in the window started at edge 16.
    for (int i = 1; i < 16; i++) cycle(i >= 3 && i <= 7, 1'b1, 1'b0);
    check_outs("level_win", 4, 1, 1'b1, AL);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0);
    check_outs("level_empty", 4, 0, 1'b1, AL);

    // Abort a partial window at window cycle 9.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(i == 1 || i == 4, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_outs("abort", 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check("abort_idle_valid", 32'(bus.win_valid), 0);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check("abort_new_valid", 32'(bus.win_valid), 32'(i == 15));
    end
    check_outs("abort_new", 2, 0, 1'b1, 1'b0);

    // clr on a window-close edge wins over the close.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(i == 1 || i == 3 || i == 5, 1'b1, 1'b0);
    check_outs("clr_pre", 3, 3, 1'b1, AL);
    for (int i = 0; i < 15; i++) cycle(i == 2, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check_outs("clr_close", 0, 0, 1'b0, 1'b0);

    // Saturation: 300 separated pulses.
    cycle(1'b0, 1'b0, 1'b1);
    nwin = 0;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        cycle(p == 0, 1'b1, 1'b0);
        if (bus.win_valid) begin
          nwin++;
          check("sat_win_le8", 32'(bus.win_cnt <= 8), 1);
        end
      end
    end
    check("sat_total", 32'(bus.total_cnt), MAXV);
    check("sat_windows", nwin, 37);

    // Asynchronous reset mid-window, observed before the next clock edge.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(i == 1 || i == 3, 1'b1, 1'b0);
    check("async_pre_total", 32'(bus.total_cnt), 2);
    #3;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 1'b0, 1'b0);
    model_reset();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0,
            $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_window_counter.md
# seq_det_window_counter

Downstream consumer of the 1011 sequence detector. Counts detection events on the detector's single-bit output, keeps a saturating running total, and reports per-window event counts over fixed windows of `WIN_LEN` clock cycles. Optionally raises a sticky alarm when a completed window reaches a threshold.

## Interface
- `CNT_W`, default 8: width of all count outputs and accumulators. Must be ≥ 2.
- `WIN_LEN`, default 16: window length in clock cycles. Must be ≥ 2.
- `THRESH`, default 3: alarm threshold, compared against the completed-window count.
- `clk` in, 1: single clock; all logic is rising-edge.
- `rst` in, 1: asynchronous, active-low reset.
- `det` in, 1: detector output (Moore `out`).
- `en` in, 1: counting enable.
- `clr` in, 1: synchronous clear, active-high.
- `total_cnt` out, CNT_W: running event total, saturating.
- `win_cnt` out, CNT_W: event count of the last completed window.
- `win_valid` out, 1: one-cycle pulse when `win_cnt` updates.
- `alarm` out, 1: sticky threshold alarm (see Configuration).

## Operation
- Event definition: `event = det & ~det_q & en`, where `det_q` is `det` registered.
  - `det` held high for N cycles counts as exactly 1 event.
  - `det_q` always tracks `det`, including while `en` = 0 and during `clr`.
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- IDLE, `en` = 1: go to RUN. The current edge is window cycle 0: `wc` ← 1, `acc` ← `event`.
- IDLE, `en` = 0: hold. `wc` = 0, `acc` = 0.
- RUN, `en` = 0: abort the partial window. Go to IDLE, `wc` ← 0, `acc` ← 0, no `win_valid`. `total_cnt`, `win_cnt` and `alarm` are retained.
- RUN, `en` = 1, `wc` < WIN_LEN−1: `wc` ← `wc`+1, `acc` ← sat(`acc`+`event`).
- RUN, `en` = 1, `wc` = WIN_LEN−1 (window close):
  - `win_cnt` ← sat(`acc`+`event`), `win_valid` ← 1.
  - `acc` ← 0, `wc` ← 0, stay in RUN. Windows are back-to-back with no gap cycle.
- `total_cnt` ← sat(`total_cnt`+`event`) on every edge, independent of FSM state.
- Saturation: all adds clamp at 2^CNT_W−1. There is no wrap.
- `wc` width is clog2(WIN_LEN).
- `clr` = 1 has priority over every other action on that edge:
  - `total_cnt`, `win_cnt`, `acc`, `wc` ← 0; `win_valid` ← 0; `alarm` ← 0.
  - FSM ← IDLE. An event on the same edge is discarded.
- Simultaneous window close and `clr`: `clr` wins, no `win_valid`.
- Reset (`rst` low, any time including mid-window): all registers, `det_q` and every output go to 0 immediately; FSM → IDLE.

## Timing
- Reset values: `total_cnt` = 0, `win_cnt` = 0, `win_valid` = 0, `alarm` = 0.
- `det` rises before edge k: `total_cnt` shows the increment after edge k (1-cycle latency).
- `en` first sampled high at edge 0: window closes at edge WIN_LEN−1. `win_cnt`/`win_valid` are valid in the cycle following that edge.
- `win_valid` is high for exactly one cycle per completed window, every WIN_LEN cycles while `en` stays high.
- `alarm` sets in the same cycle as the `win_valid` that triggers it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SEQ_DET_WIN_ALARM_EN`.
- Defined:
  - At window close, if the closing count ≥ THRESH, `alarm` ← 1.
  - `alarm` stays high until `clr` or `rst`; later windows below threshold do not clear it.
- Undefined:
  - The `alarm` port still exists and is tied to 0.
  - No threshold-compare logic is present. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset: hold `rst` low for 3 cycles with `det` toggling → all outputs 0. Release with `en` = 0 → outputs stay 0.
- Window count: `en` = 1 from edge 0, single-cycle `det` pulses at edges 2, 6 and 11 → `win_valid` pulses once after edge 15 with `win_cnt` = 3 and `total_cnt` = 3. `alarm` = 1 with the macro, 0 without.
- Level filtering: `det` high for 5 consecutive cycles inside a window → `total_cnt` +1, `win_cnt` = 1. Next window has 0 events → `win_cnt` = 0, `alarm` (if previously set) stays 1.
- Saturation: 300 separated pulses with `en` = 1 → `total_cnt` = 255. A window of WIN_LEN = 16 cannot exceed 8 events, so `win_cnt` ≤ 8.
- Abort: 2 events, then `en` low at window cycle 9 → no `win_valid`, `total_cnt` = 2, `win_cnt` unchanged. Re-assert `en` → a new full 16-cycle window starts.
- Clear/reset priority:
  - `clr` on the window-close edge → no `win_valid`, all counts and `alarm` 0.
  - Async `rst` mid-window → outputs 0 without waiting for a clock edge.
